// File: rtl/pulse_period_meter_if.sv
// pulse_period_meter_if
//   Result channel of the pulse period meter: an averaged period with a
//   valid/ready handshake, plus the one-cycle timeout and overrun flags.
//
//   period_out   : averaged period in clock cycles (W bits)
//   period_valid : period_out holds an unconsumed result
//   period_ready : consumer accepts the result this cycle
//   timeout      : one-cycle pulse, no edge seen within MAX_PERIOD cycles
//   overrun      : one-cycle pulse, a completed result was dropped
//
//   master : the meter (drives the result and flags)
//   slave  : the consumer (drives period_ready)
interface pulse_period_meter_if #(
  parameter int W = 11
);
  logic [W-1:0] period_out;
  logic         period_valid;
  logic         period_ready;
  logic         timeout;
  logic         overrun;

  modport master (
    output period_out,
    output period_valid,
    output timeout,
    output overrun,
    input  period_ready
  );

  modport slave (
    input  period_out,
    input  period_valid,
    input  timeout,
    input  overrun,
    output period_ready
  );
endinterface

// File: rtl/pulse_period_meter.sv
// pulse_period_meter
//   Measures the spacing between rising edges of a (possibly asynchronous)
//   tick stream in clk_in cycles, averages 2**AVG_LOG2 consecutive periods
//   and presents the truncated average on a valid/ready result channel.
//   Used to recover the divide factor of a clock divider or tick generator.
//
//   clk_in   : sole clock
//   reset    : synchronous, active-high reset
//   enable   : measurement enable; low discards any partial window
//   pulse_in : tick stream, synchronized internally
//   meas     : result channel (period_out/period_valid/period_ready,
//              timeout and overrun pulses)
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | disabled, partial state cleared; waits for enable
//   ARMED   | enabled, waiting for the first edge that opens a period
//   MEASURE | counting cycles between edges and accumulating periods
module pulse_period_meter #(
  parameter int CLK_RATE    = 100_000_000,
  parameter int MAX_PERIOD  = 1024,
  parameter int AVG_LOG2    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      pulse_in,
  pulse_period_meter_if.master      meas
);

  localparam int W    = $clog2(MAX_PERIOD + 1);
  localparam int SW   = W + AVG_LOG2;
  localparam int NW   = AVG_LOG2 + 1;
  localparam int NAVG = 1 << AVG_LOG2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  // Parameter legality; CLK_RATE is informational and only checked here.
  if (CLK_RATE < 1) begin : g_bad_clk_rate
    $error("pulse_period_meter: CLK_RATE must be positive");
  end
  if (MAX_PERIOD < 1) begin : g_bad_max_period
    $error("pulse_period_meter: MAX_PERIOD must be at least 1");
  end
  if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg_log2
    $error("pulse_period_meter: AVG_LOG2 must be in 0..4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("pulse_period_meter: SYNC_STAGES must be at least 2");
  end

  // ---------------------------------------------------------------------
  // Front end: synchronizer and rising-edge detect
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   strobe;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe = sync_q[SYNC_STAGES-1] & ~sync_prev;

  // ---------------------------------------------------------------------
  // Measurement state
  // ---------------------------------------------------------------------
  logic [1:0]    state, state_d;
  logic [W-1:0]  cnt, cnt_d;
  logic [SW-1:0] acc, acc_d;
  logic [NW-1:0] nper, nper_d;

  logic [SW-1:0] sum;
  logic [SW-1:0] avg_full;
  logic [W-1:0]  result;
  logic          last_period;
  logic          cnt_at_max;
  logic          complete;
  logic          expire;

  // The closing period is folded in combinationally so the result is
  // available in the same cycle as the completing strobe.
  assign sum         = acc + SW'(cnt);
  assign avg_full    = sum >> AVG_LOG2;
  assign result      = avg_full[W-1:0];
  assign last_period = (nper == NW'(NAVG - 1));
  assign cnt_at_max  = (cnt == W'(MAX_PERIOD));

  // enable low overrides both events, so they are qualified with it here.
  assign complete = enable && (state == ST_MEASURE) && strobe && last_period;
  assign expire   = enable && (state == ST_MEASURE) && !strobe && cnt_at_max;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    acc_d   = acc;
    nper_d  = nper;

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      nper_d  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_d = ST_ARMED;
        end

        ST_ARMED: begin
          if (strobe) begin
            state_d = ST_MEASURE;
            cnt_d   = W'(1);
            acc_d   = '0;
            nper_d  = '0;
          end
        end

        ST_MEASURE: begin
          if (strobe) begin
            // The edge closing this period opens the next one.
            cnt_d = W'(1);
            if (last_period) begin
              acc_d  = '0;
              nper_d = '0;
            end else begin
              acc_d  = sum;
              nper_d = nper + NW'(1);
            end
          end else if (cnt_at_max) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
            acc_d   = '0;
            nper_d  = '0;
          end else begin
            cnt_d = cnt + W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          acc_d   = '0;
          nper_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      nper  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      acc   <= acc_d;
      nper  <= nper_d;
    end
  end

  // ---------------------------------------------------------------------
  // Result channel and flags
  // ---------------------------------------------------------------------
  logic [W-1:0] period_q;
  logic         valid_q;
  logic         timeout_q;
  logic         overrun_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      // A result arriving while the previous one is still held is dropped;
      // the held data is never overwritten.
      overrun_q <= complete && valid_q && !meas.period_ready;

      if (complete && (!valid_q || meas.period_ready)) begin
        period_q <= result;
        valid_q  <= 1'b1;
      end else if (valid_q && meas.period_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign meas.period_out   = period_q;
  assign meas.period_valid = valid_q;
  assign meas.timeout      = timeout_q;
  assign meas.overrun      = overrun_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
`timescale 1ns/10ps
module tb_pulse_period_meter;

  localparam int MAX_PERIOD = 16;
  localparam int AVG_LOG2   = 2;
  localparam int W          = $clog2(MAX_PERIOD + 1);

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic pulse_drv;
  logic pulse_async;
  logic async_mode;
  logic pulse_in;

  pulse_period_meter_if #(.W(W)) bus ();

  assign pulse_in = async_mode ? pulse_async : pulse_drv;

  pulse_period_meter #(
    .CLK_RATE   (100_000_000),
    .MAX_PERIOD (MAX_PERIOD),
    .AVG_LOG2   (AVG_LOG2),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in  (clk),
    .reset   (reset),
    .enable  (enable),
    .pulse_in(pulse_in),
    .meas    (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  int to_cnt = 0, to_hi = 0, to_cyc = -1;
  int ovr_cnt = 0, ovr_hi = 0;
  int async_cnt = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_to = 1'b0, prev_ovr = 1'b0;
  logic [W-1:0] prev_out = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_valid && !prev_ready && bus.period_valid)
        chk("hold_stable", int'(bus.period_out), int'(prev_out));
      if (bus.period_valid && bus.period_ready) begin
        if (async_mode) begin
          async_cnt++;
          checks++;
          if (bus.period_out < 7 || bus.period_out > 8) begin
            errors++;
            $display("FAIL async_result: got %0d expected 7 or 8", bus.period_out);
          end
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0d expected none", bus.period_out);
        end else begin
          chk("result", int'(bus.period_out), exp_q.pop_front());
        end
      end
      if (bus.timeout) begin
        to_hi++;
        to_cyc = cyc;
        if (!prev_to) to_cnt++;
      end
      if (bus.overrun) begin
        ovr_hi++;
        if (!prev_ovr) ovr_cnt++;
      end
    end
    prev_valid = bus.period_valid;
    prev_ready = bus.period_ready;
    prev_out   = bus.period_out;
    prev_to    = bus.timeout;
    prev_ovr   = bus.overrun;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One tick, then g-1 quiet cycles: consecutive calls space edges by g.
  task automatic tick_gap(input int g);
    pulse_drv = 1'b1;
    step(1);
    pulse_drv = 1'b0;
    step(g - 1);
  endtask

  // Opening tick, four gaps, closing tick.
  task automatic window(input int a, input int b, input int c, input int d);
    tick_gap(a);
    tick_gap(b);
    tick_gap(c);
    tick_gap(d);
    tick_gap(3);
  endtask

  task automatic restart();
    enable = 1'b0;
    step(2);
    enable = 1'b1;
    step(2);
  endtask

  task automatic drain(input int exp);
    exp_q.push_back(exp);
    bus.period_ready = 1'b1;
    step(1);
    bus.period_ready = 1'b0;
    chk("drain_valid_low", int'(bus.period_valid), 0);
  endtask

  int t4_cyc;

  initial begin
    reset            = 1'b1;
    enable           = 1'b0;
    pulse_drv        = 1'b0;
    pulse_async      = 1'b0;
    async_mode       = 1'b0;
    bus.period_ready = 1'b0;
    step(3);
    chk("rst_period_out", int'(bus.period_out), 0);
    chk("rst_valid", int'(bus.period_valid), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    reset = 1'b0;
    step(1);

    // Basic: ticks every 3 cycles, two results of 3, latency of 3 edges.
    bus.period_ready = 1'b1;
    restart();
    exp_q.push_back(3);
    exp_q.push_back(3);
    repeat (4) tick_gap(3);
    pulse_drv = 1'b1;
    step(1);
    pulse_drv = 1'b0;
    step(1);
    chk("latency_early", int'(bus.period_valid), 0);
    step(1);
    chk("latency_valid", int'(bus.period_valid), 1);
    repeat (4) tick_gap(3);
    step(2);

    // Truncating averages.
    restart();
    exp_q.push_back(4);
    window(4, 5, 4, 5);
    step(2);
    restart();
    exp_q.push_back(7);
    window(7, 7, 7, 8);
    step(2);

    // Backpressure: first result held, second dropped with overrun.
    bus.period_ready = 1'b0;
    restart();
    repeat (9) tick_gap(4);
    chk("bp_overrun_count", ovr_cnt, 1);
    enable = 1'b0;
    step(2);
    chk("bp_valid_held", int'(bus.period_valid), 1);
    chk("bp_data_held", int'(bus.period_out), 4);
    drain(4);

    // Enable drop mid-window with a held result.
    restart();
    repeat (7) tick_gap(5);
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    step(1);
    repeat (3) tick_gap(5);
    step(2);
    chk("en_valid_held", int'(bus.period_valid), 1);
    chk("en_data_held", int'(bus.period_out), 5);
    chk("en_overrun_count", ovr_cnt, 1);
    chk("en_timeout_count", to_cnt, 0);
    enable = 1'b0;
    step(2);
    drain(5);

    // Reset mid-window with a held result.
    restart();
    repeat (7) tick_gap(6);
    chk("rm_valid_before", int'(bus.period_valid), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rm_period_out", int'(bus.period_out), 0);
    chk("rm_valid", int'(bus.period_valid), 0);
    chk("rm_timeout", int'(bus.timeout), 0);
    chk("rm_overrun", int'(bus.overrun), 0);
    bus.period_ready = 1'b1;
    step(2);
    exp_q.push_back(6);
    window(6, 6, 6, 6);
    step(2);

    // Timeout boundaries: gap 16 is a valid period, gap 17 times out.
    restart();
    exp_q.push_back(16);
    exp_q.push_back(10);
    repeat (4) tick_gap(16);
    t4_cyc = cyc;
    tick_gap(17);
    window(10, 10, 10, 10);
    step(2);
    enable = 1'b0;
    step(2);
    chk("to_count", to_cnt, 1);
    chk("to_width", to_hi, 1);
    chk("to_timing", to_cyc, t4_cyc + 19);

    // Asynchronous ticks, period 7.3 clock cycles.
    async_mode = 1'b1;
    enable     = 1'b1;
    step(2);
    #3.3;
    repeat (1000) begin
      pulse_async = 1'b1;
      #36.5;
      pulse_async = 1'b0;
      #36.5;
    end
    step(5);
    enable = 1'b0;
    step(3);
    async_mode = 1'b0;
    chk("async_results", async_cnt, 249);

    step(3);
    chk("queue_empty", exp_q.size(), 0);
    chk("overrun_total", ovr_cnt, 1);
    chk("overrun_width", ovr_hi, 1);
    chk("timeout_total", to_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
